// File: rtl/if_stage_buf.sv
// Fetch front end: drives a one-cycle-latency instruction ROM and queues (pc, inst)
// pairs in a small FIFO that decode drains through a valid/ready handshake.
module if_stage_buf #(
  parameter int                 ADDR_W   = 32,
  parameter int                 INST_W   = 32,
  parameter int                 DEPTH    = 4,
  parameter logic [ADDR_W-1:0]  RESET_PC = '0,
  parameter logic [ADDR_W-1:0]  PC_STEP  = ADDR_W'(4)
) (
  input  logic              clk,
  input  logic              rst,
  output logic [ADDR_W-1:0] rom_addr_o,
  output logic              rom_ce_o,
  input  logic [INST_W-1:0] rom_data_i,
  input  logic              branch_flag_i,
  input  logic [ADDR_W-1:0] branch_target_i,
  output logic              id_valid_o,
  input  logic              id_ready_i,
  output logic [ADDR_W-1:0] id_pc_o,
  output logic [INST_W-1:0] id_inst_o
);

  localparam int PTR_W   = $clog2(DEPTH);
  localparam int CNT_W   = PTR_W + 1;
  localparam int ENTRY_W = ADDR_W + INST_W;

  logic [ADDR_W-1:0]  pc_q;
  logic [ADDR_W-1:0]  issue_pc_q;
  logic               inflight_q;
  logic               drop_q;
  logic [CNT_W-1:0]   occ_q;
  logic [PTR_W-1:0]   rd_ptr_q;
  logic [PTR_W-1:0]   wr_ptr_q;
  logic [ENTRY_W-1:0] mem [DEPTH];

  logic               pop;
  logic               push;
  logic               issue;
  logic [CNT_W:0]     demand;
  logic [ENTRY_W-1:0] head;

  assign id_valid_o = (occ_q != '0);
  assign pop        = id_valid_o & id_ready_i;

  // Slots already spoken for after this cycle; a fetch is only issued when its
  // response is guaranteed a free slot, so a returning word is never dropped.
  assign demand = {1'b0, occ_q} + (CNT_W+1)'(inflight_q) - (CNT_W+1)'(pop);
  assign issue  = !rst && !branch_flag_i && (demand < (CNT_W+1)'(DEPTH));

  // A response landing in the redirect cycle belongs to the old path.
  assign push = inflight_q & !drop_q & !branch_flag_i;

  assign rom_ce_o   = issue;
  assign rom_addr_o = pc_q;

  assign head      = mem[rd_ptr_q];
  assign id_pc_o   = id_valid_o ? head[ENTRY_W-1:INST_W] : '0;
  assign id_inst_o = id_valid_o ? head[INST_W-1:0]       : '0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q       <= RESET_PC;
      issue_pc_q <= RESET_PC;
      inflight_q <= 1'b0;
      drop_q     <= 1'b0;
      occ_q      <= '0;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
    end else begin
      inflight_q <= issue;
      if (issue) begin
        pc_q       <= pc_q + PC_STEP;
        issue_pc_q <= pc_q;
      end
      if (branch_flag_i) begin
        // The head popped this cycle is the delay slot; everything behind it goes.
        pc_q     <= branch_target_i;
        drop_q   <= 1'b0;
        occ_q    <= '0;
        rd_ptr_q <= wr_ptr_q;
      end else begin
        if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
        if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
        case ({push, pop})
          2'b10:   occ_q <= occ_q + CNT_W'(1);
          2'b01:   occ_q <= occ_q - CNT_W'(1);
          default: occ_q <= occ_q;
        endcase
      end
    end
  end

  // Storage needs no reset: entries are only visible while occupancy covers them.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr_q] <= {issue_pc_q, rom_data_i};
  end

endmodule

// File: tb/tb_if_stage_buf.sv
// Directed bench for if_stage_buf: throughput, stall/fill, redirects, async reset,
// and PC wrap-around on a narrow-address instance.
module tb_if_stage_buf;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic [31:0] rom_addr;
  logic        rom_ce;
  logic [31:0] rom_data;
  logic        br;
  logic [31:0] tgt;
  logic        id_valid;
  logic        id_ready;
  logic [31:0] id_pc;
  logic [31:0] id_inst;

  logic [7:0]  w_rom_addr;
  logic        w_rom_ce;
  logic [31:0] w_rom_data;
  logic        w_valid;
  logic [7:0]  w_pc;
  logic [31:0] w_inst;

  int n_cmp = 0;
  int n_err = 0;
  int issued;

  if_stage_buf dut (
    .clk(clk), .rst(rst),
    .rom_addr_o(rom_addr), .rom_ce_o(rom_ce), .rom_data_i(rom_data),
    .branch_flag_i(br), .branch_target_i(tgt),
    .id_valid_o(id_valid), .id_ready_i(id_ready),
    .id_pc_o(id_pc), .id_inst_o(id_inst)
  );

  if_stage_buf #(.ADDR_W(8), .INST_W(32), .DEPTH(4), .RESET_PC(8'hF8), .PC_STEP(8'd4)) u_wrap (
    .clk(clk), .rst(rst),
    .rom_addr_o(w_rom_addr), .rom_ce_o(w_rom_ce), .rom_data_i(w_rom_data),
    .branch_flag_i(1'b0), .branch_target_i(8'h00),
    .id_valid_o(w_valid), .id_ready_i(1'b1),
    .id_pc_o(w_pc), .id_inst_o(w_inst)
  );

  function automatic logic [31:0] rom_word(input logic [31:0] a);
    return a ^ 32'hCAFE_0000;
  endfunction

  always @(posedge clk) begin
    rom_data   <= rom_word(rom_addr);
    w_rom_data <= rom_word({24'h0, w_rom_addr});
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; id_ready = 1'b0; br = 1'b0; tgt = 32'h0;
    #2;
    check("rst_addr",  rom_addr, 32'h0);
    check("rst_ce",    32'(rom_ce), 32'h0);
    check("rst_valid", 32'(id_valid), 32'h0);
    check("rst_pc",    id_pc, 32'h0);
    check("rst_inst",  id_inst, 32'h0);
    check("rst_w_addr", {24'h0, w_rom_addr}, 32'hF8);
    repeat (2) @(posedge clk);
    #1; rst = 1'b0;

    // cycle 1: first fetch issued at RESET_PC
    id_ready = 1'b1; #1;
    check("c1_ce",    32'(rom_ce), 32'h1);
    check("c1_addr",  rom_addr, 32'h0);
    check("c1_valid", 32'(id_valid), 32'h0);
    tick;
    check("c2_valid", 32'(id_valid), 32'h0);
    check("c2_addr",  rom_addr, 32'h4);
    tick;
    // cycles 3..6: one instruction per cycle, wrap instance crosses 0xFF
    for (int k = 0; k < 4; k++) begin
      check("run_valid", 32'(id_valid), 32'h1);
      check("run_pc",    id_pc, 32'(4 * k));
      check("run_inst",  id_inst, rom_word(32'(4 * k)));
      check("wrap_pc",   {24'h0, w_pc}, {24'h0, 8'(8'hF8 + 8'(4 * k))});
      check("wrap_inst", w_inst, rom_word({24'h0, 8'(8'hF8 + 8'(4 * k))}));
      tick;
    end

    // cycles 7..12: stall fills the buffer, exactly two more fetches go out
    id_ready = 1'b0; issued = 0;
    for (int k = 0; k < 6; k++) begin
      #1;
      issued += int'(rom_ce);
      check("stall_head", id_pc, 32'h10);
      tick;
    end
    check("stall_issued", issued, 32'd2);
    check("full_ce",      32'(rom_ce), 32'h0);
    check("full_addr",    rom_addr, 32'h20);
    check("full_valid",   32'(id_valid), 32'h1);

    // cycles 13..14: drain resumes in order
    id_ready = 1'b1; #1;
    check("drain_ce",  32'(rom_ce), 32'h1);
    check("drain_pc0", id_pc, 32'h10);
    tick;
    check("drain_pc1", id_pc, 32'h14);
    tick;

    // cycle 15: redirect while 0x18 is consumed
    br = 1'b1; tgt = 32'h100; #1;
    check("br_ce",        32'(rom_ce), 32'h0);
    check("br_slot_pc",   id_pc, 32'h18);
    check("br_slot_inst", id_inst, rom_word(32'h18));
    tick;
    br = 1'b0; #1;
    check("br_flush_valid", 32'(id_valid), 32'h0);
    check("br_tgt_addr",    rom_addr, 32'h100);
    check("br_tgt_ce",      32'(rom_ce), 32'h1);
    tick;
    check("br_gap_valid", 32'(id_valid), 32'h0);
    tick;
    check("br_tgt_pc",   id_pc, 32'h100);
    check("br_tgt_inst", id_inst, rom_word(32'h100));
    tick;
    check("post_br_pc", id_pc, 32'h104);
    tick;

    // cycles 20..21: back-to-back redirects, second one on an empty buffer
    check("dbl_slot_pc", id_pc, 32'h108);
    br = 1'b1; tgt = 32'h200; #1;
    check("dbl_ce0", 32'(rom_ce), 32'h0);
    tick;
    tgt = 32'h300; #1;
    check("dbl_addr",  rom_addr, 32'h200);
    check("dbl_ce1",   32'(rom_ce), 32'h0);
    check("dbl_valid", 32'(id_valid), 32'h0);
    tick;
    br = 1'b0; #1;
    check("dbl_tgt_addr", rom_addr, 32'h300);
    check("dbl_tgt_ce",   32'(rom_ce), 32'h1);
    tick;
    check("dbl_gap_valid", 32'(id_valid), 32'h0);
    tick;
    check("dbl_tgt_valid", 32'(id_valid), 32'h1);
    check("dbl_tgt_pc",    id_pc, 32'h300);
    tick;

    // fill, then assert reset between clock edges
    id_ready = 1'b0;
    repeat (8) tick;
    check("full2_valid", 32'(id_valid), 32'h1);
    check("full2_ce",    32'(rom_ce), 32'h0);
    check("full2_pc",    id_pc, 32'h304);
    #2; rst = 1'b1; #1;
    check("arst_valid", 32'(id_valid), 32'h0);
    check("arst_pc",    id_pc, 32'h0);
    check("arst_inst",  id_inst, 32'h0);
    check("arst_ce",    32'(rom_ce), 32'h0);
    check("arst_addr",  rom_addr, 32'h0);
    check("arst_w_valid", 32'(w_valid), 32'h0);
    @(posedge clk);
    #1; rst = 1'b0; id_ready = 1'b1; #1;
    check("rerun_ce",   32'(rom_ce), 32'h1);
    check("rerun_addr", rom_addr, 32'h0);
    tick;
    tick;
    check("rerun_valid", 32'(id_valid), 32'h1);
    check("rerun_pc",    id_pc, 32'h0);
    check("rerun_inst",  id_inst, rom_word(32'h0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
